cla_serial_addsub_ctrl: RTL and testbench
=========================================

// Module: cla_serial_addsub_ctrl
// PURPOSE
//   Sequencer that performs WIDTH = 4*NIBBLES bit add/subtract by cycling one 4-bit
//   carry-lookahead nibble slice once per clock, LSB nibble first, rippling carry in a register.
//   Gives wide add/sub on the team's 4-bit CLA datapath without replicating it NIBBLES times.
//   Valid/ready on both sides; sits between an operand source and a result consumer.
// PARAMETERS
//   NIBBLES  4  number of 4-bit slices; WIDTH = 4*NIBBLES (legal range 1..16)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand request
//   in_ready   out  1      operands accepted when in_valid & in_ready
//   a          in   WIDTH  operand A (two's complement / unsigned)
//   b          in   WIDTH  operand B
//   sel        in   1      0 = A+B, 1 = A-B
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result when out_valid & out_ready
//   result     out  WIDTH  sum/difference, mod 2^WIDTH
//   c_out      out  1      carry out of MSB nibble (sub: 1 = no borrow, A>=B unsigned)
//   overflow   out  1      signed overflow of the full WIDTH operation
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, c_out=0, overflow=0, idx=0.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid: latch a_r=a, bm_r = sel ? ~b : b, carry=sel, idx=0,
//     clear result; -> RUN. sel captured only here; later changes on a/b/sel ignored.
//   RUN: in_ready=0. Each cycle nibble n=idx: {cy,s} = CLA4(a_r[4n+3:4n], bm_r[4n+3:4n], carry),
//     using p_i=a^b, g_i=a&b and full lookahead carries c1..c4 incl. carry-in term.
//     result[4n+3:4n] <= s; carry <= cy; idx <= idx+1.
//     Final nibble (idx==NIBBLES-1): c_out <= cy;
//       overflow <= (a_r[MSB]==bm_r[MSB]) & (s[3]!=a_r[MSB]); -> DONE.
//   DONE: out_valid=1; result/c_out/overflow held stable. On out_ready -> IDLE next cycle
//     (out_valid drops). in_ready stays 0 in DONE: no same-cycle accept of next operands.
//   Latency: acceptance edge T; RUN occupies NIBBLES cycles; out_valid high from
//     cycle T+NIBBLES+1. Throughput: one op per NIBBLES+2 cycles minimum.
//   result/c_out/overflow undefined-for-use (but deterministic) when out_valid=0;
//     partial nibbles visible during RUN.
//   Wrap-around: result modulo 2^WIDTH; c_out reports the wrap; overflow is signed only.
//   NIBBLES=1: single RUN cycle, matches standalone 4-bit CLA add/sub with correct overflow.
//   rst mid-RUN or in DONE: abandon op, return to reset values next edge; no out_valid.
//   in_valid while busy: ignored (in_ready=0); source must hold request.
//   out_ready high with out_valid low: no effect.
// TESTING (NIBBLES=4)
//   add 0x1234+0x4321 -> result 0x5555, c_out 0, overflow 0, out_valid 5 cycles after accept
//   add 0x7FFF+0x0001 -> 0x8000, c_out 0, overflow 1; add 0xFFFF+0x0001 -> 0x0000, c_out 1, ov 0
//   sub 0x0000-0x0001 -> 0xFFFF, c_out 0, ov 0; sub 0x8000-0x0001 -> 0x7FFF, c_out 1, ov 1
//   backpressure: out_ready low 5 cycles in DONE -> out_valid, result stable, in_ready 0 throughout
//   rst asserted on 2nd RUN cycle -> next cycle IDLE, in_ready 1, out_valid 0, outputs 0
//   back-to-back: in_valid held with new operands -> 2nd op accepted first IDLE cycle after handoff

Source files
------------

// File: rtl/cla_serial_addsub_ctrl_if.sv
// Operand/result handshake bundle for the serial CLA add/sub sequencer.
// master = operand source + result consumer, slave = sequencer.
interface cla_serial_addsub_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, c_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, c_out, overflow, busy
    );
endinterface

// File: rtl/cla_serial_addsub_ctrl.sv
// Wide add/sub built from one 4-bit carry-lookahead slice reused once per clock,
// LSB nibble first, with the inter-nibble carry held in a register.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p, g;
    logic       c1, c2, c3;

    assign p  = a ^ b;
    assign g  = a & b;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

module cla_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                     clk,
    input logic                     rst,
    cla_serial_addsub_ctrl_if.slave bus
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_nx;
    logic [NIBBLES-1:0][3:0]  a_r, bm_r, res_r;
    logic                     carry, c_out_r, ov_r;
    logic [IW-1:0]            idx;
    logic                     last;
    logic [3:0]               nib_s;
    logic                     nib_cy;

    assign last = (idx == IW'(NIBBLES - 1));

    cla4 u_cla4 (
        .a  (a_r[idx]),
        .b  (bm_r[idx]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_cy)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_nx = RUN;
            end
            RUN:  if (last) state_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and sel seeds the carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            bm_r    <= '0;
            res_r   <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            ov_r    <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r   <= bus.a;
                    bm_r  <= bus.sel ? ~bus.b : bus.b;
                    carry <= bus.sel;
                    idx   <= '0;
                    res_r <= '0;
                end
                RUN: begin
                    res_r[idx] <= nib_s;
                    carry      <= nib_cy;
                    idx        <= idx + 1'b1;
                    if (last) begin
                        c_out_r <= nib_cy;
                        ov_r    <= (a_r[NIBBLES-1][3] == bm_r[NIBBLES-1][3])
                                 & (nib_s[3] != a_r[NIBBLES-1][3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = res_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = ov_r;
endmodule

// File: tb/tb_cla_serial_addsub_ctrl.sv
// Directed-vector bench with a queue scoreboard and an independent output monitor.
module tb_cla_serial_addsub_ctrl;
    localparam int NIBBLES = 4;
    localparam int WIDTH   = 4 * NIBBLES;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_ov = 1'b0;
    exp_t sbq[$];
    int   latq[$];

    always #5 clk = ~clk;

    cla_serial_addsub_ctrl_if #(.NIBBLES(NIBBLES)) ifc ();

    cla_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: samples just after the falling edge, i.e. what the next rising edge acts on.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                latq.delete();
                prev_ov = 1'b0;
            end else begin
                if (ifc.in_valid && ifc.in_ready) latq.push_back(cyc);
                if (ifc.out_valid && !prev_ov) begin
                    if (latq.size() > 0) chk("latency", 32'(cyc - latq.pop_front()), NIBBLES + 1);
                    else                 chk("out_valid_no_accept", 32'(ifc.out_valid), 0);
                end
                if (ifc.out_valid && ifc.out_ready) begin
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("result",   32'(ifc.result),   32'(e.r));
                        chk("c_out",    32'(ifc.c_out),    32'(e.c));
                        chk("overflow", 32'(ifc.overflow), 32'(e.v));
                    end else begin
                        chk("out_unexpected", 32'(ifc.out_valid), 0);
                    end
                end
                prev_ov = ifc.out_valid;
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sel,
                         input logic [WIDTH-1:0] r, input logic c, input logic v);
        int n = 0;
        exp_t e;
        e.r = r; e.c = c; e.v = v;
        sbq.push_back(e);
        ifc.a = a; ifc.b = b; ifc.sel = sel; ifc.in_valid = 1'b1;
        while (!ifc.in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", 32'(ifc.in_ready), 1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.a = '0; ifc.b = '0; ifc.sel = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ifc.busy || sbq.size() > 0) && n < 200) begin @(negedge clk); n++; end
        chk("idle_wait", 32'(ifc.busy), 0);
    endtask

    initial begin
        int n;
        ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.sel = 1'b0; ifc.out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready",  32'(ifc.in_ready),  1);
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_busy",      32'(ifc.busy),      0);
        chk("rst_result",    32'(ifc.result),    0);
        chk("rst_c_out",     32'(ifc.c_out),     0);
        chk("rst_overflow",  32'(ifc.overflow),  0);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        issue(16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        wait_idle();

        // Backpressure: consumer stalls five DONE cycles.
        ifc.out_ready = 1'b0;
        issue(16'hA3C5, 16'h0F0F, 1'b0, 16'hB2D4, 1'b0, 1'b0);
        n = 0;
        while (!ifc.out_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(ifc.out_valid), 1);
            chk("bp_result",    32'(ifc.result),    32'h0000B2D4);
            chk("bp_in_ready",  32'(ifc.in_ready),  0);
            @(negedge clk);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop_out_valid", 32'(ifc.out_valid), 0);
        chk("bp_back_in_ready",  32'(ifc.in_ready),  1);

        // Reset on the second RUN cycle abandons the operation.
        ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.sel = 1'b0; ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(ifc.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready",  32'(ifc.in_ready),  1);
        chk("abort_out_valid", 32'(ifc.out_valid), 0);
        chk("abort_busy_low",  32'(ifc.busy),      0);
        chk("abort_result",    32'(ifc.result),    0);
        chk("abort_c_out",     32'(ifc.c_out),     0);
        chk("abort_overflow",  32'(ifc.overflow),  0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);

        // Back-to-back: request held, operands (and sel) change while busy.
        begin
            exp_t e1, e2;
            e1.r = 16'h3333; e1.c = 1'b0; e1.v = 1'b0;
            e2.r = 16'h8000; e2.c = 1'b1; e2.v = 1'b0;
            sbq.push_back(e1);
            sbq.push_back(e2);
        end
        chk("b2b_first_ready", 32'(ifc.in_ready), 1);
        ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.sel = 1'b0; ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.a = 16'h9000; ifc.b = 16'h1000; ifc.sel = 1'b1;
        n = 0;
        while (!(ifc.out_valid && ifc.out_ready) && n < 50) begin @(negedge clk); n++; end
        chk("b2b_handoff", 32'(ifc.out_valid), 1);
        @(negedge clk);
        chk("b2b_accept_ready", 32'(ifc.in_ready), 1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_idle();

        @(negedge clk); @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
